// File: rtl/compress_mc_if.sv
// Sample stream bundle for compress_mc: linear samples in, G.711 codes out,
// each direction with its own valid/ready handshake.
interface compress_mc_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_sr;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic              out_law;
  logic [7:0]        out_sp;

  modport master (
    output in_valid, in_ch, in_sr, out_ready,
    input  in_ready, out_valid, out_ch, out_law, out_sp
  );

  modport slave (
    input  in_valid, in_ch, in_sr, out_ready,
    output in_ready, out_valid, out_ch, out_law, out_sp
  );
endinterface

// File: rtl/compress_mc.sv
// Multi-channel pipelined linear-to-G.711 compressor with per-channel law
// selection and saturating per-channel clip counters.
module compress_mc #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_law,
  compress_mc_if.slave     bus,
  input  logic [CH_W-1:0]  stat_ch,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_clip
);

  localparam logic [13:0] MU_CLIP = 14'd8158;
  localparam logic [13:0] MU_BIAS = 14'd33;

  function automatic logic ch_ok(input logic [CH_W-1:0] c);
    return 32'(c) < 32'(CHANNELS);
  endfunction

  function automatic logic [13:0] mu_abs(input logic signed [13:0] x);
    logic signed [14:0] w;
    w = 15'(x);
    return w[14] ? 14'(-w) : 14'(w);
  endfunction

  function automatic logic [12:0] mu_sat_bias(input logic [13:0] mag);
    logic [13:0] s;
    s = (mag > MU_CLIP) ? MU_CLIP : mag;
    return 13'(s + MU_BIAS);
  endfunction

  // One's-complement of a negative value equals -x-1, the A-law magnitude.
  function automatic logic [11:0] a_abs(input logic signed [12:0] x);
    return x[12] ? ~x[11:0] : x[11:0];
  endfunction

  function automatic logic [7:0] mu_code(input logic [12:0] m, input logic neg);
    logic [2:0] seg;
    logic [3:0] mant;
    seg = '0;
    for (int b = 6; b <= 12; b++) begin
      if (m[b]) seg = 3'(b - 5);
    end
    mant = 4'(m >> (4'(seg) + 4'd1));
    return {1'b0, seg, mant} ^ (neg ? 8'h7F : 8'hFF);
  endfunction

  function automatic logic [7:0] a_code(input logic [11:0] mag, input logic neg);
    logic [2:0] seg;
    logic [3:0] mant;
    seg = '0;
    for (int b = 5; b <= 11; b++) begin
      if (mag[b]) seg = 3'(b - 4);
    end
    mant = (seg == 3'd0) ? 4'(mag >> 1) : 4'(mag >> seg);
    return {1'b0, seg, mant} ^ (neg ? 8'h55 : 8'hD5);
  endfunction

  logic [CHANNELS-1:0] law_q, law_d;
  logic [CNT_W-1:0]    clip_q [CHANNELS];
  logic [CNT_W-1:0]    clip_d [CHANNELS];

  logic                     vld_p0_q, ok_p0_q, law_p0_q;
  logic signed [DATA_W-1:0] sr_p0_q;
  logic [CH_W-1:0]          ch_p0_q;

  logic                     vld_p1_q, ok_p1_q, law_p1_q, neg_p1_q, clip_p1_q;
  logic [12:0]              val_p1_q;
  logic [CH_W-1:0]          ch_p1_q;

  logic                     out_valid_q, out_law_q, out_clip_q;
  logic [7:0]               out_sp_q;
  logic [CH_W-1:0]          out_ch_q;

  logic en, xfer, in_ok;

  assign en            = bus.out_ready | ~out_valid_q;
  assign xfer          = out_valid_q & bus.out_ready;
  assign in_ok         = ch_ok(bus.in_ch);
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sp    = out_sp_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_law   = out_law_q;
  assign stat_clip     = ch_ok(stat_ch) ? clip_q[stat_ch] : '0;

  always_comb begin
    law_d = law_q;
    if (cfg_we && ch_ok(cfg_ch)) law_d[cfg_ch] = cfg_law;
  end

  // Clear wins over a same-cycle increment on the same channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clip_d[i] = clip_q[i];
      if (stat_clr && 32'(stat_ch) == i)
        clip_d[i] = '0;
      else if (xfer && out_clip_q && 32'(out_ch_q) == i && clip_q[i] != {CNT_W{1'b1}})
        clip_d[i] = clip_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      law_q <= '0;
      for (int i = 0; i < CHANNELS; i++) clip_q[i] <= '0;
    end else begin
      law_q <= law_d;
      for (int i = 0; i < CHANNELS; i++) clip_q[i] <= clip_d[i];
    end
  end

  // S1: capture sample, tag and the law register as it stood before this edge
  always_ff @(posedge clk) begin
    if (reset)   vld_p0_q <= 1'b0;
    else if (en) vld_p0_q <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sr_p0_q  <= $signed(bus.in_sr);
      ch_p0_q  <= bus.in_ch;
      ok_p0_q  <= in_ok;
      law_p0_q <= in_ok & law_q[bus.in_ch];
    end
  end

  // S2: sign, magnitude, clip flag and bias
  logic signed [13:0] x_mu;
  logic signed [12:0] x_a;
  logic [13:0]        mu_mag;
  logic               unused_sr_lsb;

  assign x_mu          = sr_p0_q[DATA_W-1 -: 14];
  assign x_a           = sr_p0_q[DATA_W-1 -: 13];
  assign mu_mag        = mu_abs(x_mu);
  assign unused_sr_lsb = ^sr_p0_q;

  always_ff @(posedge clk) begin
    if (reset)   vld_p1_q <= 1'b0;
    else if (en) vld_p1_q <= vld_p0_q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      ch_p1_q  <= ch_p0_q;
      ok_p1_q  <= ok_p0_q;
      law_p1_q <= law_p0_q;
      if (law_p0_q) begin
        neg_p1_q  <= x_a[12];
        clip_p1_q <= 1'b0;
        val_p1_q  <= {1'b0, a_abs(x_a)};
      end else begin
        neg_p1_q  <= x_mu[13];
        clip_p1_q <= mu_mag > MU_CLIP;
        val_p1_q  <= mu_sat_bias(mu_mag);
      end
    end
  end

  // S3: segment, mantissa and mask; registered outputs held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sp_q    <= '0;
      out_ch_q    <= '0;
      out_law_q   <= 1'b0;
      out_clip_q  <= 1'b0;
    end else if (en) begin
      out_valid_q <= vld_p1_q;
      out_sp_q    <= law_p1_q ? a_code(val_p1_q[11:0], neg_p1_q)
                              : mu_code(val_p1_q, neg_p1_q);
      out_ch_q    <= ch_p1_q;
      out_law_q   <= law_p1_q;
      out_clip_q  <= clip_p1_q & ok_p1_q & ~law_p1_q;
    end
  end

endmodule
